// File: rtl/mmio_button_in.sv
// rtl/mmio_button_in.sv - memory-mapped debounced button input port
// STATE/EVENT/RAW register window; EVENT is write-1-to-clear and drives irq.
module mmio_button_in #(
   parameter int          NBTN       = 6,
   parameter int          DB_CYCLES  = 50000,
   parameter int          CNT_W      = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h100,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NBTN-1:0] btn_in,
   input  logic            we,
   input  logic [31:0]     a,
   input  logic [31:0]     wd,
   output logic [31:0]     rd,
   output logic            sel,
   output logic            irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [NBTN-1:0]  in_log;
   logic [NBTN-1:0]  sync1_q, sync2_q;
   logic [NBTN-1:0]  state_q, state_d;
   logic [NBTN-1:0]  event_q, event_d;
   logic [NBTN-1:0]  rise;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];
   logic             irq_q;
   logic             ev_wr;
   logic             unused_ok;

   assign in_log    = ACTIVE_LOW ? ~btn_in : btn_in;
   assign sel       = (a[31:4] == BASE_ADDR[31:4]);
   assign ev_wr     = we & sel & (a[3:2] == 2'd1);
   assign irq       = irq_q;
   assign unused_ok = ^{a[1:0], wd};

   // Any return to the debounced level before the count completes restarts it.
   always_comb begin
      state_d = state_q;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != state_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               state_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // A press landing on the same edge as a clear keeps its flag set.
   always_comb begin
      rise    = state_d & ~state_q;
      event_d = (ev_wr ? (event_q & ~wd[NBTN-1:0]) : event_q) | rise;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= '0;
         event_q <= '0;
         irq_q   <= 1'b0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= in_log;
         sync2_q <= sync1_q;
         state_q <= state_d;
         event_q <= event_d;
         irq_q   <= |event_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      rd = '0;
      if (sel) begin
         case (a[3:2])
            2'd0:    rd = 32'(state_q);
            2'd1:    rd = 32'(event_q);
            2'd2:    rd = 32'(sync2_q);
            default: rd = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_button_in.sv
// tb/tb_mmio_button_in.sv - bench for mmio_button_in
// Reference model: a level flips once sync2 has disagreed with it for DB consecutive edges.
module tb_mmio_button_in;

   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  btn_in;
   logic        we;
   logic [31:0] a, wd, rd;
   logic        sel, irq;

   int checks = 0;
   int errors = 0;

   logic [5:0] hist[$];
   logic [5:0] seen_q[$];
   logic [5:0] m_state, m_event;
   logic [5:0] cur_btn;

   mmio_button_in #(
      .NBTN(6), .DB_CYCLES(DB), .CNT_W(4), .BASE_ADDR(32'h100), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .we(we), .a(a), .wd(wd),
      .rd(rd), .sel(sel), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic model_reset();
      hist.delete();
      seen_q.delete();
      m_state = '0;
      m_event = '0;
   endtask

   function automatic logic [5:0] m_raw();
      return (hist.size() >= 2) ? hist[hist.size()-2] : 6'h00;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] addr);
      if (addr[31:4] != 28'h10) return 32'h0;
      case (addr[3:2])
         2'd0:    return {26'h0, m_state};
         2'd1:    return {26'h0, m_event};
         2'd2:    return {26'h0, m_raw()};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic [5:0] btn, input logic w,
                             input logic [31:0] addr, input logic [31:0] data);
      logic [5:0] seen, old, rise;
      int k, n;
      hist.push_back(~btn);
      k = hist.size() - 1;
      seen = (k >= 2) ? hist[k-2] : 6'h00;
      seen_q.push_back(seen);
      n = seen_q.size();
      old = m_state;
      for (int b = 0; b < 6; b++) begin
         bit all_diff;
         all_diff = (n >= DB);
         for (int j = 1; j <= DB && j <= n; j++)
            if (seen_q[n-j][b] == old[b]) all_diff = 1'b0;
         if (all_diff) m_state[b] = ~old[b];
      end
      rise = m_state & ~old;
      if (w && addr[31:4] == 28'h10 && addr[3:2] == 2'd1) m_event = m_event & ~data[5:0];
      m_event = m_event | rise;
   endtask

   task automatic cycle(input logic [5:0] btn, input logic w,
                        input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      btn_in = btn; we = w; a = addr; wd = data;
      @(posedge clk);
      if (reset) model_reset();
      else model_edge(btn, w, addr, data);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; btn_in = 6'h3F; cur_btn = 6'h3F; we = 1'b0; a = 32'h0; wd = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd_a0 got %h exp 0", rd); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel_a0 got %b exp 0", sel); end
      for (int r = 0; r < 3; r++) begin
         a = 32'h100 + 32'(r * 4); #1;
         checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", r, rd); end
      end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
   endtask

   task automatic test_press_latency();
      cur_btn = 6'h3E;
      for (int e = 0; e <= DB + 1; e++) begin
         cycle(cur_btn, 1'b0, 32'h100, 32'h0);
         a = 32'h108; #1;
         checks++; if (rd !== ((e >= 1) ? 32'h1 : 32'h0))
            begin errors++; $display("FAIL latency_raw e=%0d got %h", e, rd); end
         a = 32'h100; #1;
         checks++; if (rd !== ((e == DB + 1) ? 32'h1 : 32'h0))
            begin errors++; $display("FAIL latency_state e=%0d got %h", e, rd); end
         a = 32'h104; #1;
         checks++; if (rd !== ((e == DB + 1) ? 32'h1 : 32'h0))
            begin errors++; $display("FAIL latency_event e=%0d got %h", e, rd); end
         checks++; if (irq !== (e == DB + 1))
            begin errors++; $display("FAIL latency_irq e=%0d got %b", e, irq); end
      end
   endtask

   task automatic test_glitch();
      for (int rep = 0; rep < 2; rep++) begin
         repeat (3) cycle(cur_btn & ~6'h04, 1'b0, 32'h100, 32'h0);
         repeat (DB + 3) cycle(cur_btn, 1'b0, 32'h100, 32'h0);
         a = 32'h100; #1;
         checks++; if (rd !== 32'h1) begin errors++; $display("FAIL glitch_state rep=%0d got %h exp 1", rep, rd); end
         a = 32'h104; #1;
         checks++; if (rd !== 32'h1) begin errors++; $display("FAIL glitch_event rep=%0d got %h exp 1", rep, rd); end
      end
   endtask

   task automatic test_w1c();
      cur_btn = cur_btn & ~6'h02;
      repeat (DB + 2) cycle(cur_btn, 1'b0, 32'h104, 32'h0);
      a = 32'h104; #1;
      checks++; if (rd !== 32'h3) begin errors++; $display("FAIL w1c_pre got %h exp 3", rd); end
      cycle(cur_btn, 1'b1, 32'h104, 32'h1);
      a = 32'h104; #1;
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL w1c_bit0 got %h exp 2", rd); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq1 got %b exp 1", irq); end
      cycle(cur_btn, 1'b1, 32'h104, 32'h2);
      a = 32'h104; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_bit1 got %h exp 0", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq0 got %b exp 0", irq); end
   endtask

   task automatic test_set_wins();
      cur_btn = cur_btn | 6'h02;
      repeat (DB + 3) cycle(cur_btn, 1'b0, 32'h100, 32'h0);
      cur_btn = cur_btn & ~6'h02;
      for (int e = 0; e <= DB + 1; e++)
         cycle(cur_btn, (e == DB + 1), 32'h104, 32'h2);
      a = 32'h104; #1;
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL setwins_event got %h exp 2", rd); end
      a = 32'h100; #1;
      checks++; if (rd !== 32'h3) begin errors++; $display("FAIL setwins_state got %h exp 3", rd); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL setwins_irq got %b exp 1", irq); end
   endtask

   task automatic test_window();
      logic [31:0] addrs [5];
      addrs = '{32'h0FC, 32'h110, 32'h100, 32'h108, 32'h10C};
      for (int i = 0; i < 5; i++) begin
         cycle(cur_btn, 1'b1, addrs[i], 32'hFFFF_FFFF);
         a = 32'h104; #1;
         checks++; if (rd !== 32'h2) begin errors++; $display("FAIL window_wr %h got %h exp 2", addrs[i], rd); end
      end
      a = 32'h0FC; #1;
      checks++; if (sel !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL window_0fc sel=%b rd=%h exp 0/0", sel, rd); end
      a = 32'h110; #1;
      checks++; if (sel !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL window_110 sel=%b rd=%h exp 0/0", sel, rd); end
      a = 32'h10C; #1;
      checks++; if (sel !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL window_10c sel=%b rd=%h exp 1/0", sel, rd); end
      a = 32'h107; #1;
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL window_unaligned got %h exp 2", rd); end
   endtask

   task automatic test_reset_midcount();
      cur_btn = cur_btn & ~6'h08;
      repeat (3) cycle(cur_btn, 1'b0, 32'h100, 32'h0);
      reset = 1'b1;
      model_reset();
      #1;
      for (int r = 0; r < 3; r++) begin
         a = 32'h100 + 32'(r * 4); #1;
         checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_reg%0d got %h exp 0", r, rd); end
      end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", irq); end
      cur_btn = 6'h3F;
      cycle(cur_btn, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (DB + 3) cycle(cur_btn, 1'b0, 32'h100, 32'h0);
      a = 32'h100; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_state_after got %h exp 0", rd); end
      a = 32'h104; #1;
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_event_after got %h exp 0", rd); end
   endtask

   task automatic test_random();
      logic [5:0]  drive;
      logic        w;
      logic [31:0] waddr, raddr;
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 11) == 0) cur_btn[b] = ~cur_btn[b];
         drive = cur_btn;
         if ($urandom_range(0, 29) == 0) drive[$urandom_range(0, 5)] ^= 1'b1;
         w = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 6))
            0:       waddr = 32'h0FC;
            1:       waddr = 32'h100;
            2, 3:    waddr = 32'h104;
            4:       waddr = 32'h108;
            5:       waddr = 32'h10C;
            default: waddr = 32'h110;
         endcase
         cycle(drive, w, waddr, $urandom);
         checks++; if (irq !== (|m_event)) begin errors++; $display("FAIL rand_irq c=%0d got %b exp %b", c, irq, |m_event); end
         for (int r = 0; r < 3; r++) begin
            a = 32'h100 + 32'(r * 4); #1;
            checks++; if (rd !== exp_rd(a)) begin errors++; $display("FAIL rand_reg%0d c=%0d got %h exp %h", r, c, rd, exp_rd(a)); end
         end
         raddr = 32'h0F0 + 32'($urandom_range(0, 47));
         a = raddr; #1;
         checks++; if (rd !== exp_rd(raddr) || sel !== (raddr[31:4] == 28'h10))
            begin errors++; $display("FAIL rand_addr %h c=%0d got %h/%b exp %h", raddr, c, rd, sel, exp_rd(raddr)); end
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_w1c();
      test_set_wins();
      test_window();
      test_reset_midcount();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
